// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: size codes, FSM states,
// and the byte-lane select helper.
package mem_pkg;

  localparam logic [1:0] MEM_B = 2'b00;
  localparam logic [1:0] MEM_H = 2'b01;
  localparam logic [1:0] MEM_W = 2'b10;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } mem_state_e;

  // Size code 2'b11 falls through to a full word
  function automatic logic [3:0] lane_sel(
    input logic [1:0] a,
    input logic [1:0] sz
  );
    logic [3:0] be;
    unique case (sz)
      MEM_B:   be = 4'b0001 << a;
      MEM_H:   be = a[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_ext.sv
// Load lane extract plus sign/zero extension.
// Purely combinational; word loads pass through untouched.
module mem_load_ext
  import mem_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_addr,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sb;
  logic        w_sh;

  always_comb begin
    unique case (i_addr)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_addr[1] ? i_word[31:16]
                       : i_word[15:0];
    w_sb = w_byte[7] & ~i_unsigned;
    w_sh = w_half[15] & ~i_unsigned;
    unique case (i_size)
      MEM_B:   o_data = {{24{w_sb}}, w_byte};
      MEM_H:   o_data = {{16{w_sh}}, w_half};
      MEM_W:   o_data = i_word;
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MIPS MEM stage: byte-lane data RAM, optional multi-cycle
// access FSM, and the MEM/WB pipeline register.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int unsigned LATENCY     = 1
)(
  input  logic        clk,
  input  logic        rstn,
  input  logic        stall,
  input  logic        flush,
  input  logic        valid_in,
  input  logic [31:0] alu_result,
  input  logic [31:0] mem_addr,
  input  logic [31:0] write_data,
  input  logic [4:0]  write_reg_in,
  input  logic [31:0] inst_in,
  input  logic        reg_write_in,
  input  logic        mem_read_in,
  input  logic        mem_write_in,
  input  logic        mem_to_reg_in,
  input  logic [1:0]  mem_size_in,
  input  logic        mem_unsigned_in,
  output logic        busy,
  output logic        valid_out,
  output logic [31:0] inst_out,
  output logic [31:0] mem_read_data,
  output logic [31:0] final_result,
  output logic [4:0]  write_reg_out,
  output logic        reg_write_out,
  output logic        mem_to_reg_out,
  output logic        addr_err_out,
  output logic [31:0] err_addr_out
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [32:0] LIMIT =
    33'(DEPTH_WORDS) << 2;
  localparam logic [2:0] CNT_INIT =
    3'(LATENCY - 1);

  logic [31:0]   r_mem [DEPTH_WORDS];
  mem_state_e    r_state;
  logic [2:0]    r_cnt;

  logic [31:0]   w_off;
  logic [AW-1:0] w_idx;
  logic          w_in_range;
  logic          w_misal;
  logic          w_err;
  logic          w_store;
  logic          w_load;
  logic          w_acc;
  logic          w_upd;
  logic          w_bub;
  logic          w_we;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [31:0]   w_rword;
  logic [31:0]   w_ext;
  logic [31:0]   w_ld_data;

  assign w_off      = mem_addr - BASE_ADDR;
  assign w_idx      = w_off[AW+1:2];
  assign w_in_range = {1'b0, w_off} < LIMIT;

  always_comb begin
    unique case (mem_size_in)
      MEM_B:   w_misal = 1'b0;
      MEM_H:   w_misal = mem_addr[0];
      default: w_misal = |mem_addr[1:0];
    endcase
  end

  assign w_err = valid_in
               & (mem_read_in | mem_write_in)
               & (~w_in_range | w_misal);

  // A load+store slot behaves as a store
  assign w_store = valid_in & mem_write_in & ~w_err;
  assign w_load  = valid_in & mem_read_in
                 & ~mem_write_in & ~w_err;
  assign w_acc   = w_store | w_load;

  assign w_be = lane_sel(mem_addr[1:0], mem_size_in);

  always_comb begin
    unique case (mem_size_in)
      MEM_B:   w_wdata = {4{write_data[7:0]}};
      MEM_H:   w_wdata = {2{write_data[15:0]}};
      default: w_wdata = write_data;
    endcase
  end

  assign w_rword = r_mem[w_idx];

  mem_load_ext u_ext (
    .i_word     (w_rword),
    .i_addr     (mem_addr[1:0]),
    .i_size     (mem_size_in),
    .i_unsigned (mem_unsigned_in),
    .o_data     (w_ext)
  );

  assign w_ld_data = w_load ? w_ext : 32'h0;

  // w_upd: slot lands in MEM/WB; w_bub: access starts waiting
  always_comb begin
    w_upd = 1'b0;
    w_bub = 1'b0;
    busy  = 1'b0;
    if (LATENCY == 1) begin
      w_upd = ~stall & ~flush;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          busy  = w_acc & ~stall;
          w_upd = ~stall & ~flush & ~w_acc;
          w_bub = ~stall & ~flush & w_acc;
        end
        S_WAIT: begin
          busy  = (r_cnt != 3'd1);
          w_upd = (r_cnt == 3'd1)
                & ~stall & ~flush;
        end
        default: ;
      endcase
    end
  end

  assign w_we = w_store & w_upd;

  always_ff @(posedge clk) begin
    if (w_we) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) begin
          r_mem[w_idx][8*k +: 8] <= w_wdata[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
    end else if (LATENCY > 1) begin
      if (flush) begin
        r_state <= S_IDLE;
        r_cnt   <= 3'd0;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            if (w_bub) begin
              r_state <= S_WAIT;
              r_cnt   <= CNT_INIT;
            end
          end
          S_WAIT: begin
            if (r_cnt != 3'd1) begin
              r_cnt <= r_cnt - 3'd1;
            end else if (!stall) begin
              r_state <= S_IDLE;
              r_cnt   <= 3'd0;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_out      <= 1'b0;
      inst_out       <= 32'h0;
      mem_read_data  <= 32'h0;
      final_result   <= 32'h0;
      write_reg_out  <= 5'd0;
      reg_write_out  <= 1'b0;
      mem_to_reg_out <= 1'b0;
      addr_err_out   <= 1'b0;
      err_addr_out   <= 32'h0;
    end else if (flush || w_bub) begin
      valid_out     <= 1'b0;
      reg_write_out <= 1'b0;
      addr_err_out  <= 1'b0;
    end else if (w_upd) begin
      valid_out      <= valid_in;
      inst_out       <= inst_in;
      mem_read_data  <= w_ld_data;
      final_result   <= mem_to_reg_in ? w_ld_data
                                      : alu_result;
      write_reg_out  <= write_reg_in;
      reg_write_out  <= valid_in & reg_write_in
                      & ~w_err;
      mem_to_reg_out <= mem_to_reg_in;
      addr_err_out   <= w_err;
      err_addr_out   <= w_err ? mem_addr : 32'h0;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench: one single-cycle and one 3-cycle instance
// share the stimulus; each phase checks its own instance.
module tb_mem_access_unit;

  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;

  logic        clk = 1'b0;
  logic        rstn;
  logic        stall, flush, valid_in;
  logic [31:0] alu_result, mem_addr;
  logic [31:0] write_data, inst_in;
  logic [4:0]  write_reg_in;
  logic        reg_write_in, mem_read_in;
  logic        mem_write_in, mem_to_reg_in;
  logic [1:0]  mem_size_in;
  logic        mem_unsigned_in;

  logic        a_busy, a_valid, a_rw, a_m2r, a_err;
  logic [31:0] a_inst, a_rdata, a_final, a_eaddr;
  logic [4:0]  a_wreg;
  logic        b_busy, b_valid, b_rw, b_m2r, b_err;
  logic [31:0] b_inst, b_rdata, b_final, b_eaddr;
  logic [4:0]  b_wreg;

  int n_chk = 0;
  int n_err = 0;
  int busy1_hi = 0;

  always #5 clk = ~clk;
  always @(posedge clk) if (a_busy) busy1_hi++;

  mem_access_unit #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0),
    .LATENCY     (1)
  ) u_dut1 (
    .clk (clk), .rstn (rstn),
    .stall (stall), .flush (flush),
    .valid_in (valid_in),
    .alu_result (alu_result),
    .mem_addr (mem_addr),
    .write_data (write_data),
    .write_reg_in (write_reg_in),
    .inst_in (inst_in),
    .reg_write_in (reg_write_in),
    .mem_read_in (mem_read_in),
    .mem_write_in (mem_write_in),
    .mem_to_reg_in (mem_to_reg_in),
    .mem_size_in (mem_size_in),
    .mem_unsigned_in (mem_unsigned_in),
    .busy (a_busy), .valid_out (a_valid),
    .inst_out (a_inst),
    .mem_read_data (a_rdata),
    .final_result (a_final),
    .write_reg_out (a_wreg),
    .reg_write_out (a_rw),
    .mem_to_reg_out (a_m2r),
    .addr_err_out (a_err),
    .err_addr_out (a_eaddr)
  );

  mem_access_unit #(
    .DEPTH_WORDS (1024),
    .BASE_ADDR   (32'h0),
    .LATENCY     (3)
  ) u_dut3 (
    .clk (clk), .rstn (rstn),
    .stall (stall), .flush (flush),
    .valid_in (valid_in),
    .alu_result (alu_result),
    .mem_addr (mem_addr),
    .write_data (write_data),
    .write_reg_in (write_reg_in),
    .inst_in (inst_in),
    .reg_write_in (reg_write_in),
    .mem_read_in (mem_read_in),
    .mem_write_in (mem_write_in),
    .mem_to_reg_in (mem_to_reg_in),
    .mem_size_in (mem_size_in),
    .mem_unsigned_in (mem_unsigned_in),
    .busy (b_busy), .valid_out (b_valid),
    .inst_out (b_inst),
    .mem_read_data (b_rdata),
    .final_result (b_final),
    .write_reg_out (b_wreg),
    .reg_write_out (b_rw),
    .mem_to_reg_out (b_m2r),
    .addr_err_out (b_err),
    .err_addr_out (b_eaddr)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_in = 0; stall = 0; flush = 0;
    alu_result = 0; mem_addr = 0;
    write_data = 0; inst_in = 0;
    write_reg_in = 0; reg_write_in = 0;
    mem_read_in = 0; mem_write_in = 0;
    mem_to_reg_in = 0; mem_size_in = SW;
    mem_unsigned_in = 0;
  endtask

  task automatic st(input logic [31:0] a,
                    input logic [31:0] d,
                    input logic [1:0] sz);
    idle();
    valid_in = 1; mem_write_in = 1;
    mem_addr = a; write_data = d;
    mem_size_in = sz;
    inst_in = 32'hAC00_0000 | a;
  endtask

  task automatic ld(input logic [31:0] a,
                    input logic [1:0] sz,
                    input logic u);
    idle();
    valid_in = 1; mem_read_in = 1;
    reg_write_in = 1; mem_to_reg_in = 1;
    mem_addr = a; mem_size_in = sz;
    mem_unsigned_in = u; write_reg_in = 5'd9;
    alu_result = 32'h5A5A_5A5A;
    inst_in = 32'h8C00_0000 | a;
  endtask

  task automatic alu(input logic [31:0] v);
    idle();
    valid_in = 1; reg_write_in = 1;
    alu_result = v; write_reg_in = 5'd3;
  endtask

  initial begin
    idle();
    rstn = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst valid1", 32'(a_valid), 0);
    chk("rst final1", a_final, 0);
    chk("rst rw1", 32'(a_rw), 0);
    chk("rst valid3", 32'(b_valid), 0);
    chk("rst rdata3", b_rdata, 0);
    chk("rst busy3", 32'(b_busy), 0);
    rstn = 1;

    // single-cycle instance
    st(32'h10, 32'h8000_00FF, SW); tick();
    chk("sw valid", 32'(a_valid), 1);
    chk("sw err", 32'(a_err), 0);
    ld(32'h10, SW, 0); tick();
    chk("lw rdata", a_rdata, 32'h8000_00FF);
    chk("lw final", a_final, 32'h8000_00FF);
    chk("lw rw", 32'(a_rw), 1);
    chk("lw wreg", 32'(a_wreg), 9);
    chk("lw inst", a_inst, 32'h8C00_0010);
    ld(32'h10, SB, 0); tick();
    chk("lb", a_final, 32'hFFFF_FFFF);
    ld(32'h10, SB, 1); tick();
    chk("lbu", a_final, 32'h0000_00FF);
    ld(32'h12, SH, 0); tick();
    chk("lh", a_final, 32'hFFFF_8000);
    ld(32'h12, SH, 1); tick();
    chk("lhu", a_final, 32'h0000_8000);

    st(32'h10, 32'h1122_3344, SW); tick();
    st(32'h13, 32'h1234_56AB, SB); tick();
    ld(32'h10, SW, 0); tick();
    chk("sb lane3", a_rdata, 32'hAB22_3344);
    st(32'h10, 32'h1234_BEEF, SH); tick();
    ld(32'h10, SW, 0); tick();
    chk("sh lane01", a_rdata, 32'hAB22_BEEF);

    ld(32'h11, SW, 0); tick();
    chk("mis err", 32'(a_err), 1);
    chk("mis eaddr", a_eaddr, 32'h11);
    chk("mis rw", 32'(a_rw), 0);
    chk("mis rdata", a_rdata, 0);
    st(32'h11, 32'hDEAD_DEAD, SW); tick();
    chk("mis st err", 32'(a_err), 1);
    ld(32'h10, SW, 0); tick();
    chk("mis st nowr", a_rdata, 32'hAB22_BEEF);
    chk("err cleared", 32'(a_err), 0);
    chk("eaddr cleared", a_eaddr, 0);

    st(32'h0, 32'h0, SW); tick();
    st(32'h1000, 32'hCAFE_F00D, SW); tick();
    chk("oor st err", 32'(a_err), 1);
    chk("oor eaddr", a_eaddr, 32'h1000);
    ld(32'h1000, SW, 0); tick();
    chk("oor ld rw", 32'(a_rw), 0);
    ld(32'h0, SW, 0); tick();
    chk("oor nowr", a_rdata, 0);

    alu(32'h1234_5678); tick();
    chk("alu final", a_final, 32'h1234_5678);
    chk("alu rdata", a_rdata, 0);
    chk("alu rw", 32'(a_rw), 1);
    idle(); reg_write_in = 1; alu_result = 32'hFFFF;
    tick();
    chk("bub valid", 32'(a_valid), 0);
    chk("bub rw", 32'(a_rw), 0);

    st(32'h20, 32'h1, SW); tick();
    alu(32'h1111); tick();
    st(32'h20, 32'h99, SW); stall = 1; tick();
    chk("stall hold", a_final, 32'h1111);
    tick();
    ld(32'h20, SW, 0); tick();
    chk("stall nowr", a_rdata, 32'h1);
    st(32'h20, 32'h55, SW); flush = 1; tick();
    chk("flush valid", 32'(a_valid), 0);
    ld(32'h20, SW, 0); tick();
    chk("flush nowr", a_rdata, 32'h1);
    idle();
    repeat (3) tick();

    // three-cycle instance
    st(32'h40, 32'h1234_5678, SW); #1;
    chk("l3 busy c1", 32'(b_busy), 1);
    tick();
    chk("l3 busy c2", 32'(b_busy), 1);
    chk("l3 valid c2", 32'(b_valid), 0);
    tick();
    chk("l3 busy c3", 32'(b_busy), 0);
    chk("l3 valid c3", 32'(b_valid), 0);
    tick();
    chk("l3 commit", 32'(b_valid), 1);
    ld(32'h40, SW, 0); tick(); tick();
    chk("l3 ld wait", 32'(b_valid), 0);
    tick();
    chk("l3 ld rdata", b_rdata, 32'h1234_5678);
    chk("l3 ld final", b_final, 32'h1234_5678);

    alu(32'hCAFE); #1;
    chk("l3 alu busy", 32'(b_busy), 0);
    tick();
    chk("l3 alu final", b_final, 32'hCAFE);
    chk("l3 alu valid", 32'(b_valid), 1);
    ld(32'h42, SW, 0); #1;
    chk("l3 err busy", 32'(b_busy), 0);
    tick();
    chk("l3 err", 32'(b_err), 1);
    chk("l3 eaddr", b_eaddr, 32'h42);

    st(32'h44, 32'hAAAA_5555, SW); tick();
    stall = 1; tick(); tick();
    chk("l3 stall valid", 32'(b_valid), 0);
    chk("l3 stall busy", 32'(b_busy), 0);
    stall = 0; tick();
    chk("l3 stall commit", 32'(b_valid), 1);
    ld(32'h44, SW, 0); repeat (3) tick();
    chk("l3 stall data", b_rdata, 32'hAAAA_5555);

    st(32'h44, 32'hDEAD_BEEF, SW); tick();
    flush = 1; tick();
    chk("l3 flush valid", 32'(b_valid), 0);
    idle(); tick();
    ld(32'h44, SW, 0); repeat (3) tick();
    chk("l3 flush nowr", b_rdata, 32'hAAAA_5555);

    st(32'h40, 32'h0BAD_F00D, SW); tick();
    #2;
    rstn = 0; idle();
    #1;
    chk("arst rdata", b_rdata, 0);
    chk("arst final", b_final, 0);
    chk("arst inst", b_inst, 0);
    chk("arst busy", 32'(b_busy), 0);
    tick();
    rstn = 1;
    ld(32'h40, SW, 0); repeat (3) tick();
    chk("arst nowr", b_rdata, 32'h1234_5678);
    chk("arst valid", 32'(b_valid), 1);

    chk("l1 never busy", 32'(busy1_hi), 0);
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
